// File: rtl/ifetch_unit.sv
// Instruction fetch unit: consumes the PC, fetches the instruction word over a
// req/gnt/rvalid memory handshake and queues {pc, inst, misalign} for decode.
module ifetch_unit #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic        pc_ena,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_misalign
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        misalign;
   } entry_t;

   state_e           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   entry_t           mem_q [DEPTH];
   entry_t           push_entry;
   entry_t           head;
   logic             push;
   logic             pop;
   logic             slot_free;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // The slot is judged on the registered count, so a pop only frees it next cycle.
   assign slot_free = count_q < CNT_W'(DEPTH);
   assign pc_ena    = (state_q == IDLE) & slot_free & ~flush & ~rst;
   assign imem_req  = (state_q == REQ);
   assign imem_addr = addr_q;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      push       = 1'b0;
      push_entry = '0;
      unique case (state_q)
         IDLE: begin
            if (pc_ena) begin
               if (pc_in[1:0] == 2'b00) begin
                  addr_d  = pc_in;
                  state_d = REQ;
               end else begin
                  push       = 1'b1;
                  push_entry = '{pc: pc_in, inst: 32'h0, misalign: 1'b1};
               end
            end
         end
         REQ: begin
            if (imem_gnt)   state_d = flush ? DRAIN : WAIT;
            else if (flush) state_d = IDLE;
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_d    = IDLE;
               push       = ~flush;
               push_entry = '{pc: addr_q, inst: imem_rdata, misalign: 1'b0};
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (imem_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign if_valid = (count_q != '0);
   assign pop      = if_valid & if_ready;

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= RESET_PC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // NOTE: the storage array has no reset; empty-buffer outputs are forced to zero instead.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   assign head        = mem_q[rd_ptr_q];
   assign if_pc       = if_valid ? head.pc : 32'h0;
   assign if_inst     = if_valid ? head.inst : 32'h0;
   assign if_misalign = if_valid & head.misalign;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_ifetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_ena;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_misalign;

   always #5 clk = ~clk;

   ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_in       (pc_in),
      .pc_ena      (pc_ena),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_pc       (if_pc),
      .if_inst     (if_inst),
      .if_misalign (if_misalign)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: queued decode entries plus the fate of the one memory transaction.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        mis;
   } entry_t;

   entry_t      mq[$];
   bit          m_req;    // request issued, not yet granted
   bit          m_wait;   // granted, response will be kept
   bit          m_drop;   // granted, response will be thrown away
   logic [31:0] m_addr;

   task automatic model_reset();
      mq.delete();
      m_req  = 1'b0;
      m_wait = 1'b0;
      m_drop = 1'b0;
      m_addr = RESET_PC;
   endtask

   function automatic bit exp_pc_ena();
      return !m_req && !m_wait && !m_drop && (mq.size() < DEPTH) && !flush;
   endfunction

   task automatic check_cycle();
      check("pc_ena", 32'(pc_ena), 32'(exp_pc_ena()));
      check("imem_req", 32'(imem_req), 32'(m_req));
      check("imem_addr", imem_addr, m_addr);
      check("if_valid", 32'(if_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         check("if_pc", if_pc, mq[0].pc);
         check("if_inst", if_inst, mq[0].inst);
         check("if_misalign", 32'(if_misalign), 32'(mq[0].mis));
      end
   endtask

   // Advances the model across the coming rising edge using the inputs now applied.
   task automatic model_edge();
      bit     ena;
      bit     pop;
      bit     push;
      entry_t e;
      ena  = exp_pc_ena();
      pop  = (mq.size() > 0) && if_ready;
      push = 1'b0;
      e    = '{pc: 32'h0, inst: 32'h0, mis: 1'b0};
      if (m_req) begin
         if (imem_gnt) begin
            m_req = 1'b0;
            if (flush) m_drop = 1'b1;
            else       m_wait = 1'b1;
         end else if (flush) begin
            m_req = 1'b0;
         end
      end else if (m_wait) begin
         if (imem_rvalid) begin
            m_wait = 1'b0;
            if (!flush) begin
               push = 1'b1;
               e    = '{pc: m_addr, inst: imem_rdata, mis: 1'b0};
            end
         end else if (flush) begin
            m_wait = 1'b0;
            m_drop = 1'b1;
         end
      end else if (m_drop) begin
         if (imem_rvalid) m_drop = 1'b0;
      end else begin
         if (imem_rvalid) $display("note: protocol violation, imem_rvalid with no transaction outstanding (t=%0t)", $time);
         if (ena) begin
            if (pc_in[1:0] == 2'b00) begin
               m_req  = 1'b1;
               m_addr = pc_in;
            end else begin
               push = 1'b1;
               e    = '{pc: pc_in, inst: 32'h0, mis: 1'b1};
            end
         end
      end
      if (flush) begin
         mq.delete();
      end else begin
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back(e);
      end
   endtask

   task automatic step(input bit f, input bit g, input bit rv, input logic [31:0] rd,
                       input bit rdy, input logic [31:0] pc);
      @(negedge clk);
      flush       = f;
      imem_gnt    = g;
      imem_rvalid = rv;
      imem_rdata  = rd;
      if_ready    = rdy;
      pc_in       = pc;
      #1;
      check_cycle();
      model_edge();
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input bit rdy);
      step(1'b0, 1'b0, 1'b0, 32'h0, rdy, pc);
      step(1'b0, 1'b1, 1'b0, 32'h0, rdy, pc + 32'h100);
      step(1'b0, 1'b0, 1'b1, data, rdy, pc + 32'h200);
   endtask

   initial begin
      logic [31:0] pc;
      bit          f, g, rv, rdy;

      rst = 1'b1; flush = 1'b0; pc_in = 32'h0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
      model_reset();
      #12;
      check("rst_pc_ena", 32'(pc_ena), 32'h0);
      check("rst_req", 32'(imem_req), 32'h0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_valid", 32'(if_valid), 32'h0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_inst", if_inst, 32'h0);
      check("rst_misalign", 32'(if_misalign), 32'h0);
      flush = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Basic fetch
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0000);
      check("basic_pc_ena", 32'(pc_ena), 32'h1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0004);
      check("basic_req", 32'(imem_req), 32'h1);
      check("basic_addr", imem_addr, 32'h0040_0000);
      step(1'b0, 1'b0, 1'b1, 32'h2008_0005, 1'b1, 32'h0040_0004);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0004);
      check("basic_valid", 32'(if_valid), 32'h1);
      check("basic_if_pc", if_pc, 32'h0040_0000);
      check("basic_if_inst", if_inst, 32'h2008_0005);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);

      // Backpressure
      fetch(32'h0040_0000, 32'hA000_0001, 1'b0);
      fetch(32'h0040_0004, 32'hA000_0002, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0040_0008);
         check("bp_pc_ena", 32'(pc_ena), 32'h0);
         check("bp_req", 32'(imem_req), 32'h0);
      end
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0008);
      check("bp_pop0_pc", if_pc, 32'h0040_0000);
      check("bp_pop0_ena", 32'(pc_ena), 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0008);
      check("bp_pop1_pc", if_pc, 32'h0040_0004);
      check("bp_pop1_ena", 32'(pc_ena), 32'h1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'hA000_0003, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("bp_third_pc", if_pc, 32'h0040_0008);

      // Grant stall
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0040_0010);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0040_0014);
         check("stall_req", 32'(imem_req), 32'h1);
         check("stall_addr", imem_addr, 32'h0040_0010);
         check("stall_pc_ena", 32'(pc_ena), 32'h0);
      end
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0040_0014);
      step(1'b0, 1'b0, 1'b1, 32'h1111_2222, 1'b0, 32'h0040_0014);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0014);
      check("stall_valid", 32'(if_valid), 32'h1);
      check("stall_inst", if_inst, 32'h1111_2222);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
      check("stall_one_entry", 32'(if_valid), 32'h0);

      // Flush in WAIT
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0020);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0024);
      check("fw_drain_ena", 32'(pc_ena), 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0040_0024);
      check("fw_resp_valid", 32'(if_valid), 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0024);
      check("fw_resume_ena", 32'(pc_ena), 32'h1);
      check("fw_discarded", 32'(if_valid), 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);

      // Misaligned PC
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0040_0002);
      check("mis_pc_ena", 32'(pc_ena), 32'h1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("mis_req", 32'(imem_req), 32'h0);
      check("mis_valid", 32'(if_valid), 32'h1);
      check("mis_flag", 32'(if_misalign), 32'h1);
      check("mis_inst", if_inst, 32'h0);
      check("mis_pc", if_pc, 32'h0040_0002);

      // Asynchronous reset in WAIT, then a stray response
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0040_0030);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      imem_gnt = 1'b0; imem_rvalid = 1'b0; flush = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_pc_ena", 32'(pc_ena), 32'h0);
      check("arst_req", 32'(imem_req), 32'h0);
      check("arst_addr", imem_addr, RESET_PC);
      check("arst_valid", 32'(if_valid), 32'h0);
      flush = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1, 32'h0040_0040);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
      check("stray_no_entry", 32'(if_valid), 32'h0);
      check("stray_req", 32'(imem_req), 32'h1);
      check("stray_addr", imem_addr, 32'h0040_0040);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         f   = ($urandom_range(0, 15) == 0);
         g   = ($urandom_range(0, 1) == 1);
         rv  = (m_wait || m_drop) && ($urandom_range(0, 9) < 4);
         rdy = ($urandom_range(0, 9) < 6);
         pc  = $urandom();
         if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
         step(f, g, rv, $urandom(), rdy, pc);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
